// File: rtl/vw_chunk_buffer_if.sv
// Handshake and data bundle between the element producer / matmul consumer
// and vw_chunk_buffer. The buffer connects through the slave modport.
// The master modport is for the producer/consumer side.
interface vw_chunk_buffer_if #(
  parameter int WorkingRegs = 4,
  parameter int NBits       = 8
);
  logic                          wr_valid;
  logic signed [NBits-1:0]       wr_data;
  logic                          wr_ready;
  logic                          in_data_ready;
  logic [WorkingRegs*NBits-1:0]  in_data;
  logic                          req_chunk_in;
  logic                          req_chunk_ptr_rst;
  logic                          vec_release;
  logic                          overflow;

  modport master (
    output wr_valid, wr_data, req_chunk_in, req_chunk_ptr_rst, vec_release,
    input  wr_ready, in_data_ready, in_data, overflow
  );

  modport slave (
    input  wr_valid, wr_data, req_chunk_in, req_chunk_ptr_rst, vec_release,
    output wr_ready, in_data_ready, in_data, overflow
  );
endinterface

// File: rtl/vw_chunk_buffer.sv
// Double-buffered staging of signed element vectors for the vector-by-weight
// matmul. Elements are written one per cycle into the write bank. A completed
// vector is presented from the read bank one WorkingRegs-wide chunk at a time.
// The chunk pointer can be advanced or rewound, so the same vector can be
// replayed once per output row.
// Optional build macro VW_CHUNK_BUF_OVERFLOW_EN: when defined, a sticky overflow
// flag records any write attempted while wr_ready is low, and a simulation
// error is raised. When undefined, overflow is tied low and dropped writes
// are silent.
module vw_chunk_buffer #(
  parameter int InVecLength = 8,
  parameter int WorkingRegs = 4,
  parameter int NBits       = 8
) (
  input logic               clk_in,
  input logic               rst_in,
  vw_chunk_buffer_if.slave  bus
);
  localparam int NumChunks = (InVecLength + WorkingRegs - 1) / WorkingRegs;
  localparam int IdxW      = (InVecLength > 1) ? $clog2(InVecLength) : 1;
  localparam int PtrW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(InVecLength - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(NumChunks - 1);

  // Only real elements are stored. Padding lanes are produced as zero by the read mux.
  logic signed [NBits-1:0] bank_q [2][InVecLength];

  logic [1:0]      full_q, full_d;
  logic            wb_q, wb_d;
  logic            rb_q, rb_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

  logic wr_ready;
  logic wr_fire;
  logic wr_last;
  logic rel;

  // Next-state for bank flags, bank selectors, write index and chunk pointer
  always_comb begin
    wr_ready = ~full_q[wb_q];
    wr_fire  = bus.wr_valid & wr_ready;
    wr_last  = wr_fire && (wr_idx_q == LastIdx);
    rel      = bus.vec_release & full_q[rb_q];
    full_d   = full_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    wr_idx_d = wr_idx_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) begin
      if (wr_last) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wr_idx_d     = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    // Write completion and release always hit different banks, so both apply
    if (rel) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
      rd_ptr_d     = '0;
    end else if (bus.req_chunk_ptr_rst) begin
      rd_ptr_d = '0;
    end else if (bus.req_chunk_in) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // Control state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      full_q   <= '0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wr_idx_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      full_q   <= full_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      wr_idx_q <= wr_idx_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Bank storage: cleared on reset, one element written per accepted write
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < InVecLength; e++) begin
          bank_q[b][e] <= '0;
        end
      end
    end else if (wr_fire) begin
      bank_q[wb_q][wr_idx_q] <= bus.wr_data;
    end
  end

  // Current chunk of the read bank, with lanes past the vector end forced to zero
  always_comb begin
    bus.in_data = '0;
    for (int i = 0; i < WorkingRegs; i++) begin
      if (int'(rd_ptr_q) * WorkingRegs + i < InVecLength) begin
        bus.in_data[i*NBits +: NBits] =
          bank_q[rb_q][IdxW'(int'(rd_ptr_q) * WorkingRegs + i)];
      end
    end
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.in_data_ready = full_q[rb_q];

`ifdef VW_CHUNK_BUF_OVERFLOW_EN
  logic overflow_q;

  // Sticky record of any write attempted while the write bank is full
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overflow_q <= 1'b0;
    end else if (bus.wr_valid && !wr_ready) begin
      overflow_q <= 1'b1;
      $error("vw_chunk_buffer: write dropped, both banks full");
    end
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_vw_chunk_buffer.sv
// Scoreboard bench for vw_chunk_buffer: expected chunks are queued as vectors
// are written and popped as the DUT presents them.
module tb_vw_chunk_buffer;
  localparam int WR = 4;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vw_chunk_buffer_if #(.WorkingRegs(WR), .NBits(NB)) bus8 ();
  vw_chunk_buffer_if #(.WorkingRegs(WR), .NBits(NB)) bus6 ();

  vw_chunk_buffer #(.InVecLength(8), .WorkingRegs(WR), .NBits(NB)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus8.slave)
  );

  vw_chunk_buffer #(.InVecLength(6), .WorkingRegs(WR), .NBits(NB)) dut6 (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus6.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [WR*NB-1:0] exp_q [$];
  logic [WR*NB-1:0] exp6_q [$];
  logic exp_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WR*NB-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [WR*NB-1:0] r;
    r = {NB'(d), NB'(c), NB'(b), NB'(a)};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write an 8-element vector base+1..base+8 and queue its two chunks
  task automatic write_vec8(input int base);
    for (int k = 1; k <= 8; k++) begin
      bus8.wr_valid = 1'b1;
      bus8.wr_data  = NB'(base + k);
      check("wr_ready_during_write", 64'(bus8.wr_ready), 64'd1);
      step();
    end
    bus8.wr_valid = 1'b0;
    exp_q.push_back(pack4(base + 1, base + 2, base + 3, base + 4));
    exp_q.push_back(pack4(base + 5, base + 6, base + 7, base + 8));
  endtask

  task automatic cmp_chunk(input string tag);
    logic [WR*NB-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(bus8.in_data), 64'(e));
    end
  endtask

  task automatic cmp_chunk6(input string tag);
    logic [WR*NB-1:0] e;
    if (exp6_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp6_q.pop_front();
      check(tag, 64'(bus6.in_data), 64'(e));
    end
  endtask

  task automatic pulse_req();
    bus8.req_chunk_in = 1'b1;
    step();
    bus8.req_chunk_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef VW_CHUNK_BUF_OVERFLOW_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    bus8.wr_valid = 1'b0; bus8.wr_data = '0; bus8.req_chunk_in = 1'b0;
    bus8.req_chunk_ptr_rst = 1'b0; bus8.vec_release = 1'b0;
    bus6.wr_valid = 1'b0; bus6.wr_data = '0; bus6.req_chunk_in = 1'b0;
    bus6.req_chunk_ptr_rst = 1'b0; bus6.vec_release = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_wr_ready", 64'(bus8.wr_ready), 64'd1);
    check("rst_in_data_ready", 64'(bus8.in_data_ready), 64'd0);
    check("rst_in_data", 64'(bus8.in_data), 64'd0);
    check("rst_overflow", 64'(bus8.overflow), 64'd0);

    // Vector 1..8: ready the cycle after the last element, chunk walk and wrap
    for (int k = 1; k <= 8; k++) begin
      bus8.wr_valid = 1'b1;
      bus8.wr_data  = NB'(k);
      check("v1_wr_ready", 64'(bus8.wr_ready), 64'd1);
      if (k == 8) check("v1_not_ready_before_last", 64'(bus8.in_data_ready), 64'd0);
      step();
    end
    bus8.wr_valid = 1'b0;
    exp_q.push_back(pack4(1, 2, 3, 4));
    exp_q.push_back(pack4(5, 6, 7, 8));
    exp_q.push_back(pack4(1, 2, 3, 4));
    check("v1_in_data_ready", 64'(bus8.in_data_ready), 64'd1);
    cmp_chunk("v1_chunk0");
    pulse_req();
    cmp_chunk("v1_chunk1");
    pulse_req();
    cmp_chunk("v1_wrap_chunk0");

    // Rewind wins over a same-cycle advance
    pulse_req();
    exp_q.push_back(pack4(5, 6, 7, 8));
    cmp_chunk("rewind_pre_chunk1");
    bus8.req_chunk_in = 1'b1;
    bus8.req_chunk_ptr_rst = 1'b1;
    step();
    bus8.req_chunk_in = 1'b0;
    bus8.req_chunk_ptr_rst = 1'b0;
    exp_q.push_back(pack4(1, 2, 3, 4));
    cmp_chunk("rewind_wins");

    // Both banks full: write dropped, then release exposes the second vector
    write_vec8(10);
    check("full_wr_ready", 64'(bus8.wr_ready), 64'd0);
    bus8.wr_valid = 1'b1;
    bus8.wr_data  = NB'(99);
    step();
    bus8.wr_valid = 1'b0;
    check("overflow_flag", 64'(bus8.overflow), 64'(exp_ovf));
    exp_q.push_front(pack4(1, 2, 3, 4));
    cmp_chunk("full_still_v1");
    bus8.vec_release = 1'b1;
    step();
    bus8.vec_release = 1'b0;
    cmp_chunk("rel_chunk0_v2");
    check("rel_in_data_ready", 64'(bus8.in_data_ready), 64'd1);
    check("rel_wr_ready", 64'(bus8.wr_ready), 64'd1);
    exp_q.delete();

    // Same-cycle completion of vector B and release of vector A (at chunk 1)
    pulse_req();
    for (int k = 1; k <= 7; k++) begin
      bus8.wr_valid = 1'b1;
      bus8.wr_data  = NB'(20 + k);
      step();
    end
    bus8.wr_data     = NB'(28);
    bus8.vec_release = 1'b1;
    step();
    bus8.wr_valid    = 1'b0;
    bus8.vec_release = 1'b0;
    exp_q.push_back(pack4(21, 22, 23, 24));
    exp_q.push_back(pack4(25, 26, 27, 28));
    check("same_cyc_in_data_ready", 64'(bus8.in_data_ready), 64'd1);
    check("same_cyc_wr_ready", 64'(bus8.wr_ready), 64'd1);
    cmp_chunk("same_cyc_chunk0");
    pulse_req();
    cmp_chunk("same_cyc_chunk1");
    bus8.vec_release = 1'b1;
    step();
    bus8.vec_release = 1'b0;
    check("one_bank_after_release", 64'(bus8.in_data_ready), 64'd0);

    // Reset mid-vector with the pointer at chunk 1
    write_vec8(30);
    exp_q.delete();
    for (int k = 1; k <= 3; k++) begin
      bus8.wr_valid = 1'b1;
      bus8.wr_data  = NB'(50 + k);
      step();
    end
    bus8.wr_valid = 1'b0;
    pulse_req();
    rst = 1'b1;
    bus8.wr_valid = 1'b1;
    bus8.wr_data  = NB'(77);
    step();
    rst = 1'b0;
    bus8.wr_valid = 1'b0;
    check("mid_rst_in_data_ready", 64'(bus8.in_data_ready), 64'd0);
    check("mid_rst_wr_ready", 64'(bus8.wr_ready), 64'd1);
    check("mid_rst_overflow", 64'(bus8.overflow), 64'd0);
    check("mid_rst_in_data", 64'(bus8.in_data), 64'd0);
    write_vec8(40);
    check("post_rst_ready", 64'(bus8.in_data_ready), 64'd1);
    cmp_chunk("post_rst_chunk0");
    pulse_req();
    cmp_chunk("post_rst_chunk1");

    // InVecLength=6: zero padding in the last chunk and two-chunk wrap
    for (int k = 1; k <= 6; k++) begin
      bus6.wr_valid = 1'b1;
      bus6.wr_data  = NB'(k);
      step();
    end
    bus6.wr_valid = 1'b0;
    exp6_q.push_back(pack4(1, 2, 3, 4));
    exp6_q.push_back(pack4(5, 6, 0, 0));
    exp6_q.push_back(pack4(1, 2, 3, 4));
    check("len6_ready", 64'(bus6.in_data_ready), 64'd1);
    cmp_chunk6("len6_chunk0");
    bus6.req_chunk_in = 1'b1;
    step();
    cmp_chunk6("len6_chunk1_pad");
    step();
    bus6.req_chunk_in = 1'b0;
    cmp_chunk6("len6_wrap");

    check("scoreboard_drained", 64'(exp_q.size() + exp6_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
